vending_machine_multi: RTL
==========================

Name: vending_machine_multi

Overview:
- Parametrised successor to the single-item vending controller.
- Supports NUM_ITEMS selectable products with per-item prices and per-item stock counters.
- Accepts coins of three denominations and returns change serially, one credit unit per cycle.
- Sits between the coin acceptor and keypad front end and the dispenser/coin-hopper drivers.

Parameters:
- NUM_ITEMS, 4, number of selectable products (2..8).
- CREDIT_W, 5, width of the credit register.
- MAX_CREDIT, 15, highest credit held; a coin that would exceed it is rejected.
- PRICE_LIST, {5'd10,5'd7,5'd3,5'd5}, packed prices, CREDIT_W bits per item; item 0 is in the LSBs.
- STOCK_W, 3, width of each stock counter.
- STOCK_INIT, 2, stock value loaded into every item on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- coin_in  in  1  one-cycle coin-accepted strobe
- coin_val  in  2  denomination: 00=1, 01=2, 10=5, 11=invalid
- item_sel  in  $clog2(NUM_ITEMS)  item selected for dispense
- dispense  in  1  vend request, level-sampled each cycle
- cancel  in  1  abort; refund all credit
- item_out  out  1  one-cycle vend pulse
- item_id  out  $clog2(NUM_ITEMS)  item vended; valid when item_out=1
- change_out  out  1  one-cycle pulse per refunded credit unit
- coin_reject  out  1  one-cycle pulse: coin rejected
- credit  out  CREDIT_W  current credit
- sold_out  out  NUM_ITEMS  bit i=1 when stock[i]==0
- busy  out  1  high in VEND or CHANGE

Behaviour:
- All outputs are registered.
- Reset values:
  - item_out, item_id, change_out, coin_reject, busy, credit: 0.
  - Every stock counter: STOCK_INIT.
  - sold_out: 0 (all 1s if STOCK_INIT=0).
  - State: COLLECT.
- Reset in any state aborts immediately. Held credit is discarded, not refunded.
- States: COLLECT, VEND, CHANGE.
- COLLECT, evaluated in priority order each cycle:
  1. cancel=1:
     - credit>0: go to CHANGE.
     - credit==0: stay in COLLECT.
     - A coin arriving in the same cycle is rejected.
  2. dispense=1 with credit>=price[item_sel] and stock[item_sel]>0:
     - Go to VEND. A coin arriving in the same cycle is rejected.
  3. dispense=1 with insufficient credit or the item sold out:
     - Ignore the request, stay in COLLECT.
     - Process a coin arriving in the same cycle normally.
  4. coin_in=1:
     - Valid coin with credit+value<=MAX_CREDIT: credit += value in the next cycle.
     - Otherwise (invalid code or overflow): credit unchanged, coin_reject=1 in the next cycle.
- VEND, one cycle:
  - item_out=1 and item_id=latched item_sel.
  - credit -= price; stock[item] -= 1.
  - sold_out updates in the same cycle as item_out.
  - Next state: CHANGE if the remaining credit is >0, else COLLECT.
- Vend latency: dispense sampled at edge N; item_out high during cycle N+1; first change_out pulse in cycle N+2.
- CHANGE:
  - Each cycle: change_out=1 and credit -= 1.
  - Return to COLLECT on the cycle after credit reaches 0.
  - Number of change_out pulses equals the credit at CHANGE entry.
  - coin_in in this state produces coin_reject. dispense and cancel are ignored.
- Width rules:
  - The credit comparison is unsigned.
  - Credit never underflows or exceeds MAX_CREDIT.
  - Stock never decrements below 0.
  - A price of 0 is legal: vend allowed at zero credit if stock>0.
- An item_sel value >= NUM_ITEMS is treated as sold out.

Optional Feature:
- Macro: VM_RESTOCK_EN.
- When defined:
  - Adds input port restock (1 bit).
  - A restock pulse in COLLECT reloads every stock counter to STOCK_INIT and clears sold_out in the next cycle.
  - restock has priority below cancel and above dispense.
  - restock is ignored in VEND and CHANGE.
- When undefined:
  - No restock port.
  - Stock can only be restored by rst.

Test Plan:
1. Reset; 2,2,1 coins (credit 5); dispense item0 (price 5) -> item_out pulse with item_id=0; credit=0; no change_out; stock0=1.
2. 5,5 coins (credit 10); dispense item1 (price 3) -> item_out; credit 7; exactly 7 change_out pulses on consecutive cycles; busy high 8 cycles; credit ends 0.
3. 5,5,5 coins (credit 15); coin 1 -> coin_reject pulse, credit stays 15; coin_val=11 -> coin_reject.
4. Credit 2; dispense item2 (price 7) -> no item_out, credit unchanged; then cancel -> 2 change_out pulses, credit 0.
5. Vend item3 twice (STOCK_INIT=2) -> sold_out[3]=1; third dispense with credit 10 is ignored; with VM_RESTOCK_EN, a restock pulse clears sold_out[3].
6. Assert rst mid-CHANGE with credit 4 -> next cycle credit 0, change_out 0, state COLLECT, all stock reloaded to 2.

Source files
------------

// File: rtl/vending_machine_multi.sv
// ----------------------------------------------------------------------------
// vending_machine_multi
//   Multi-item vending controller. It sits between the coin acceptor / keypad
//   front end and the dispenser / coin-hopper drivers. It accumulates credit,
//   vends one of NUM_ITEMS products at its own price, keeps a stock count per
//   item, and pays change back serially, one credit unit per cycle.
//
//   Optional build macro: VM_RESTOCK_EN
//     When defined, the block gains a `restock` input. A restock pulse seen
//     in COLLECT reloads every stock counter to STOCK_INIT.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   coin_in      one-cycle coin-accepted strobe
//   coin_val     coin denomination: 00=1, 01=2, 10=5, 11=invalid
//   item_sel     item selected for dispense
//   dispense     vend request, level-sampled every cycle
//   cancel       abort the transaction and refund all credit
//   restock      (VM_RESTOCK_EN only) reload all stock counters
//   item_out     one-cycle vend pulse
//   item_id      item vended; valid while item_out=1
//   change_out   one-cycle pulse per refunded credit unit
//   coin_reject  one-cycle pulse for a coin that was rejected
//   credit       current credit
//   sold_out     bit i is set while stock[i]==0
//   busy         high in VEND or CHANGE
// ----------------------------------------------------------------------------
// state     | meaning
// ----------+------------------------------------------------------------
// S_COLLECT | accept coins, wait for a dispense or cancel request
// S_VEND    | item_out pulse; choose CHANGE or COLLECT from remaining credit
// S_CHANGE  | one change_out pulse per cycle until credit reaches 0
// ----------------------------------------------------------------------------
module vending_machine_multi #(
    parameter int                            NUM_ITEMS  = 4,
    parameter int                            CREDIT_W   = 5,
    parameter int                            MAX_CREDIT = 15,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST = {5'd10, 5'd7, 5'd3, 5'd5},
    parameter int                            STOCK_W    = 3,
    parameter int                            STOCK_INIT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coin_in,
    input  logic [1:0]                   coin_val,
    input  logic [$clog2(NUM_ITEMS)-1:0] item_sel,
    input  logic                         dispense,
    input  logic                         cancel,
`ifdef VM_RESTOCK_EN
    input  logic                         restock,
`endif
    output logic                         item_out,
    output logic [$clog2(NUM_ITEMS)-1:0] item_id,
    output logic                         change_out,
    output logic                         coin_reject,
    output logic [CREDIT_W-1:0]          credit,
    output logic [NUM_ITEMS-1:0]         sold_out,
    output logic                         busy
);

    localparam int SEL_W = $clog2(NUM_ITEMS);

    typedef enum logic [1:0] {S_COLLECT, S_VEND, S_CHANGE} state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0]  stock_d [NUM_ITEMS];
    logic                item_out_q, item_out_d;
    logic [SEL_W-1:0]    item_id_q, item_id_d;
    logic                change_out_q, change_out_d;
    logic                coin_reject_q, coin_reject_d;
    logic [NUM_ITEMS-1:0] sold_out_q, sold_out_d;
    logic                busy_q, busy_d;

    logic [CREDIT_W-1:0] price_tbl [NUM_ITEMS];
    logic                sel_ok;
    logic [SEL_W-1:0]    sel_idx;
    logic [CREDIT_W-1:0] sel_price;
    logic                can_vend;
    logic                coin_valid;
    logic [CREDIT_W:0]   coin_value;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            price_tbl[i] = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
        end
    end

    // Out-of-range selections behave as sold out; the index is clamped so
    // the table lookups never read past the arrays.
    always_comb begin
        sel_ok    = (int'(item_sel) < NUM_ITEMS);
        sel_idx   = sel_ok ? item_sel : '0;
        sel_price = price_tbl[sel_idx];
        can_vend  = sel_ok && (stock_q[sel_idx] != '0) && (credit_q >= sel_price);
    end

    // The sum is one bit wider than credit, so an overflowing coin is caught
    // instead of wrapping.
    always_comb begin
        coin_valid = 1'b1;
        coin_value = '0;
        case (coin_val)
            2'b00:   coin_value = (CREDIT_W+1)'(1);
            2'b01:   coin_value = (CREDIT_W+1)'(2);
            2'b10:   coin_value = (CREDIT_W+1)'(5);
            default: coin_valid = 1'b0;
        endcase
        coin_sum  = {1'b0, credit_q} + coin_value;
        coin_fits = coin_valid && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    end

    // Outputs are registered. Each output is computed for the state being
    // entered, so item_out lines up with VEND and change_out with CHANGE.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        stock_d       = stock_q;
        item_out_d    = 1'b0;
        item_id_d     = item_id_q;
        change_out_d  = 1'b0;
        coin_reject_d = 1'b0;

        case (state_q)
            S_COLLECT: begin
                if (cancel) begin
                    coin_reject_d = coin_in;
                    if (credit_q != '0) begin
                        state_d      = S_CHANGE;
                        change_out_d = 1'b1;
                        credit_d     = credit_q - 1'b1;
                    end
`ifdef VM_RESTOCK_EN
                end else if (restock) begin
                    coin_reject_d = coin_in;
                    for (int i = 0; i < NUM_ITEMS; i++) begin
                        stock_d[i] = STOCK_W'(STOCK_INIT);
                    end
`endif
                end else if (dispense && can_vend) begin
                    coin_reject_d    = coin_in;
                    state_d          = S_VEND;
                    item_out_d       = 1'b1;
                    item_id_d        = sel_idx;
                    credit_d         = credit_q - sel_price;
                    stock_d[sel_idx] = stock_q[sel_idx] - 1'b1;
                end else if (coin_in) begin
                    // A refused dispense request falls through to here, so a
                    // coin in the same cycle is still taken.
                    if (coin_fits) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            S_VEND: begin
                coin_reject_d = coin_in;
                if (credit_q != '0) begin
                    state_d      = S_CHANGE;
                    change_out_d = 1'b1;
                    credit_d     = credit_q - 1'b1;
                end else begin
                    state_d = S_COLLECT;
                end
            end

            S_CHANGE: begin
                coin_reject_d = coin_in;
                if (credit_q != '0) begin
                    change_out_d = 1'b1;
                    credit_d     = credit_q - 1'b1;
                end else begin
                    state_d = S_COLLECT;
                end
            end

            default: begin
                state_d = S_COLLECT;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            sold_out_d[i] = (stock_d[i] == '0);
        end
        busy_d = (state_d != S_COLLECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_COLLECT;
            credit_q      <= '0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
            item_out_q    <= 1'b0;
            item_id_q     <= '0;
            change_out_q  <= 1'b0;
            coin_reject_q <= 1'b0;
            sold_out_q    <= (STOCK_INIT == 0) ? '1 : '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            stock_q       <= stock_d;
            item_out_q    <= item_out_d;
            item_id_q     <= item_id_d;
            change_out_q  <= change_out_d;
            coin_reject_q <= coin_reject_d;
            sold_out_q    <= sold_out_d;
            busy_q        <= busy_d;
        end
    end

    assign item_out    = item_out_q;
    assign item_id     = item_id_q;
    assign change_out  = change_out_q;
    assign coin_reject = coin_reject_q;
    assign credit      = credit_q;
    assign sold_out    = sold_out_q;
    assign busy        = busy_q;

endmodule
